// File: rtl/ldm_result_drain.sv
// Result-bank (LDM1) drain: sequential BRAM reads through a small FIFO onto a valid/ready stream.
// Optional abort_in/aborted_out ports are built when LDM_DRAIN_ABORT_EN is defined.
module ldm_result_drain #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [1:0]  BANK_SEL   = 2'b01,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
`ifdef LDM_DRAIN_ABORT_EN
    input  logic                  abort_in,
    output logic                  aborted_out,
`endif
    input  logic [ADDR_WIDTH-3:0] base_addr_in,
    input  logic [ADDR_WIDTH-2:0] len_in,
    output logic                  rd_ena_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int unsigned OFS_W = ADDR_WIDTH - 2;
    localparam int unsigned LEN_W = ADDR_WIDTH - 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t                 state_q, state_n;
    logic [OFS_W-1:0]       base_q, base_n;
    logic [LEN_W-1:0]       len_q, len_n;
    logic [LEN_W-1:0]       iss_q, iss_n;
    logic                   pend_q, pend_last_q;
    logic [CNT_W-1:0]       cnt_q, cnt_n, fill;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_q;
    logic                   push, pop, abort_hit, issue_n, tlast_n;
    logic [DATA_WIDTH-1:0]  tdata_n;
    logic [ADDR_WIDTH-1:0]  addr_n;

    // Next-state, FIFO bookkeeping and registered-output lookahead
    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        len_n     = len_q;
        iss_n     = iss_q + LEN_W'(rd_ena_out);
        abort_hit = 1'b0;
        pop       = m_tvalid && m_tready;
        fill      = cnt_q + CNT_W'(pend_q) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    base_n  = base_addr_in;
                    len_n   = len_in;
                    iss_n   = '0;
                    state_n = (len_in == '0) ? DONE : READ;
                end
            end
            READ:    if (iss_n == len_q) state_n = FLUSH;
            FLUSH:   if (fill == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

`ifdef LDM_DRAIN_ABORT_EN
        if (abort_in && (state_q == READ || state_q == FLUSH)) begin
            abort_hit = 1'b1;
            state_n   = DONE;
        end
`endif

        push = pend_q && !abort_hit;
        if (abort_hit) begin
            cnt_n    = '0;
            wr_ptr_n = '0;
            rd_ptr_n = '0;
        end else begin
            cnt_n    = fill;
            wr_ptr_n = wr_ptr_q + PTR_W'(push);
            rd_ptr_n = rd_ptr_q + PTR_W'(pop);
        end

        // Credit: next-cycle occupancy plus the read now in flight must leave a free slot
        issue_n = (state_n == READ) && (iss_n < len_n) &&
                  ((cnt_n + CNT_W'(rd_ena_out)) < CNT_W'(FIFO_DEPTH));
        addr_n  = issue_n ? {BANK_SEL, base_n + OFS_W'(iss_n)} : rd_addr_out;

        // Head register: bypass the returning word when it lands in the head slot
        tdata_n = m_tdata;
        tlast_n = 1'b0;
        if (cnt_n != '0) begin
            if (push && (rd_ptr_n == wr_ptr_q)) begin
                tdata_n = rd_data_in;
                tlast_n = pend_last_q;
            end else begin
                tdata_n = mem_q[rd_ptr_n];
                tlast_n = last_q[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            iss_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_ena_out  <= 1'b0;
            rd_addr_out <= '0;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
`ifdef LDM_DRAIN_ABORT_EN
            aborted_out <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            base_q      <= base_n;
            len_q       <= len_n;
            iss_q       <= iss_n;
            pend_q      <= rd_ena_out && !abort_hit;
            pend_last_q <= rd_ena_out && ((iss_q + LEN_W'(1)) == len_q);
            cnt_q       <= cnt_n;
            wr_ptr_q    <= wr_ptr_n;
            rd_ptr_q    <= rd_ptr_n;
            rd_ena_out  <= issue_n;
            rd_addr_out <= addr_n;
            m_tdata     <= tdata_n;
            m_tvalid    <= (cnt_n != '0);
            m_tlast     <= tlast_n;
            busy_out    <= (state_n != IDLE);
            done_out    <= (state_n == DONE);
`ifdef LDM_DRAIN_ABORT_EN
            aborted_out <= abort_hit;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]  <= rd_data_in;
            last_q[wr_ptr_q] <= pend_last_q;
        end
    end

endmodule
